// File: rtl/music_seq_if.sv
// Control and ROM bus between the song sequencer and its surroundings.
//   slave  : sequencer side (drives ROM address, beat and tone controls, status)
//   master : host/peripheral side (drives commands, ROM data, beat_finish)
interface music_seq_if #(
  parameter int unsigned ADDR_W = 6
) ();
  logic              start;
  logic              stop;
  logic              loop_en;
  logic              beat_finish;
  logic [ADDR_W-1:0] rom_addr;
  logic [23:0]       rom_data;
  logic              beat_en;
  logic [27:0]       beat_cnt_parameter;
  logic [19:0]       tone_div;
  logic              tone_en;
  logic              busy;
  logic              song_done;

  modport master (
    output start, stop, loop_en, beat_finish, rom_data,
    input  rom_addr, beat_en, beat_cnt_parameter, tone_div, tone_en, busy, song_done
  );

  modport slave (
    input  start, stop, loop_en, beat_finish, rom_data,
    output rom_addr, beat_en, beat_cnt_parameter, tone_div, tone_en, busy, song_done
  );
endinterface

// File: rtl/music_seq.sv
// Song sequencer: walks a synchronous song ROM, programs a downstream beat
// counter and tone generator per note, inserts silent gaps between notes.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - music_seq_if.slave: start/stop/loop_en/beat_finish/rom_data in;
//          rom_addr, beat_en, beat_cnt_parameter, tone_div, tone_en,
//          busy, song_done out (all registered)
module music_seq #(
  parameter logic [27:0] BEAT_UNIT  = 28'd12_500_000,
  parameter int unsigned GAP_CYCLES = 500_000,
  parameter int unsigned ADDR_W     = 6
) (
  input  logic       clk,
  input  logic       rst,
  music_seq_if.slave bus
);

  localparam int unsigned DATA_W = 24;
  localparam int unsigned DUR_W  = 4;
  localparam int unsigned DIV_W  = 20;
  localparam int unsigned CNT_W  = 28;
  localparam int unsigned PROD_W = CNT_W + DUR_W;
  localparam int unsigned GAP_W  = 32;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [GAP_W-1:0]  GAP_LAST  =
    (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP, DONE} state_t;

  state_t             state;
  logic               stop_pending;
  logic               end_forced;   // last ROM slot played: next LOAD acts as end marker
  logic [GAP_W-1:0]   gap_cnt;

  logic [DUR_W-1:0]   dur;
  logic [DIV_W-1:0]   div;
  logic [PROD_W-1:0]  beat_prod;
  logic [CNT_W-1:0]   beat_term;
  logic               at_last;

  // Decode the ROM word and precompute the beat counter terminal count
  assign dur       = bus.rom_data[DATA_W-1 -: DUR_W];
  assign div       = bus.rom_data[DIV_W-1:0];
  assign beat_prod = PROD_W'(dur) * PROD_W'(BEAT_UNIT);
  assign beat_term = CNT_W'(beat_prod - PROD_W'(1));
  assign at_last   = (bus.rom_addr == LAST_ADDR);

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= IDLE;
      stop_pending           <= 1'b0;
      end_forced             <= 1'b0;
      gap_cnt                <= '0;
      bus.rom_addr           <= '0;
      bus.beat_en            <= 1'b0;
      bus.beat_cnt_parameter <= '0;
      bus.tone_div           <= '0;
      bus.tone_en            <= 1'b0;
      bus.busy               <= 1'b0;
      bus.song_done          <= 1'b0;
    end else begin
      bus.song_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            bus.rom_addr <= '0;
            end_forced   <= 1'b0;
            bus.busy     <= 1'b1;
            state        <= FETCH;
          end
        end

        FETCH: begin
          if (bus.stop) begin
            state        <= IDLE;
            bus.busy     <= 1'b0;
            stop_pending <= 1'b0;
            end_forced   <= 1'b0;
          end else begin
            state <= LOAD;
          end
        end

        LOAD: begin
          if (bus.stop) begin
            state        <= IDLE;
            bus.busy     <= 1'b0;
            stop_pending <= 1'b0;
            end_forced   <= 1'b0;
          end else if (end_forced || dur == '0) begin
            end_forced <= 1'b0;
            if (bus.loop_en) begin
              bus.rom_addr <= '0;
              state        <= FETCH;
            end else begin
              bus.song_done <= 1'b1;
              state         <= DONE;
            end
          end else begin
            bus.tone_div           <= div;
            bus.beat_cnt_parameter <= beat_term;
            bus.beat_en            <= 1'b1;
            bus.tone_en            <= (div != '0);
            state                  <= PLAY;
          end
        end

        // A stop is only remembered here so the downstream counter finishes its note
        PLAY: begin
          if (bus.stop) stop_pending <= 1'b1;
          if (bus.beat_finish) begin
            bus.beat_en <= 1'b0;
            bus.tone_en <= 1'b0;
            if (stop_pending || bus.stop) begin
              state        <= IDLE;
              bus.busy     <= 1'b0;
              stop_pending <= 1'b0;
              end_forced   <= 1'b0;
            end else if (GAP_CYCLES == 0) begin
              if (at_last) end_forced <= 1'b1;
              else         bus.rom_addr <= bus.rom_addr + ADDR_W'(1);
              state <= FETCH;
            end else begin
              gap_cnt <= '0;
              state   <= GAP;
            end
          end
        end

        GAP: begin
          if (bus.stop) begin
            state        <= IDLE;
            bus.busy     <= 1'b0;
            stop_pending <= 1'b0;
            end_forced   <= 1'b0;
          end else if (gap_cnt == GAP_LAST) begin
            if (at_last) end_forced <= 1'b1;
            else         bus.rom_addr <= bus.rom_addr + ADDR_W'(1);
            state <= FETCH;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end

        default: begin
          state        <= IDLE;
          bus.busy     <= 1'b0;
          bus.beat_en  <= 1'b0;
          bus.tone_en  <= 1'b0;
          stop_pending <= 1'b0;
          end_forced   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/music_seq.md
MUSIC_SEQ -- requirements
Module: music_seq

Interface
REQ-001 The block SHALL have parameter BEAT_UNIT, default 28'd12_500_000, meaning clk cycles per duration unit (0.25 s at 50 MHz).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 500_000, meaning silent clk cycles inserted between notes.
REQ-003 The block SHALL have parameter ADDR_W, default 6, meaning the song ROM address width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit: a one-cycle request to begin the song from address 0.
REQ-007 The block SHALL have port stop, input, 1 bit: a one-cycle request to abort playback.
REQ-008 The block SHALL have port loop_en, input, 1 bit: when 1, the end marker restarts the song at address 0.
REQ-009 The block SHALL have port beat_finish, input, 1 bit: the end-of-note pulse from the downstream beat counter.
REQ-010 The block SHALL have port rom_addr, output, ADDR_W bits: the song ROM address.
REQ-011 The block SHALL have port rom_data, input, 24 bits: the synchronous ROM word, valid one cycle after rom_addr.
- [23:20] = duration in units; 0 = end marker.
- [19:0] = tone half-period divider; 0 = rest.
REQ-012 The block SHALL have port beat_en, output, 1 bit: the enable for the beat counter.
REQ-013 The block SHALL have port beat_cnt_parameter, output, 28 bits: the terminal count for the beat counter.
REQ-014 The block SHALL have port tone_div, output, 20 bits: the divider for the downstream tone generator.
REQ-015 The block SHALL have port tone_en, output, 1 bit: the tone generator enable.
REQ-016 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-017 The block SHALL have port song_done, output, 1 bit: a one-cycle pulse at the natural end of the song.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, LOAD, PLAY, GAP, DONE.
REQ-019 IDLE: on start=1 with stop=0, the block SHALL set rom_addr=0 and go to FETCH; if start and stop are both 1, stop SHALL win and the block SHALL stay in IDLE.
REQ-020 FETCH SHALL last exactly 1 cycle (ROM latency) and then go to LOAD.
REQ-021 LOAD with duration=0:
- loop_en=1: rom_addr=0, go to FETCH.
- loop_en=0: go to DONE.
REQ-022 LOAD with duration!=0: the block SHALL latch tone_div=rom_data[19:0] and beat_cnt_parameter=duration*BEAT_UNIT-1, truncated to 28 bits, and go to PLAY.
REQ-023 beat_cnt_parameter and tone_div SHALL stay constant from LOAD through the end of the following GAP.
REQ-024 PLAY: beat_en=1; tone_en=1 if tone_div!=0, otherwise 0 (rest).
REQ-025 PLAY: on beat_finish=1 the block SHALL go to GAP, or to IDLE if stop_pending=1.
REQ-026 A stop during PLAY SHALL set stop_pending and SHALL NOT cut the note short, so the downstream counter always ends at zero.
REQ-027 GAP: beat_en=0 and tone_en=0 for GAP_CYCLES cycles, then rom_addr+1 and go to FETCH.
REQ-028 If GAP_CYCLES=0, the block SHALL go from PLAY directly to FETCH with the address incremented.
REQ-029 A stop during GAP SHALL go to IDLE on the next edge.
REQ-030 If the note just played was at address 2^ADDR_W-1, the block SHALL treat the next entry as an end marker; rom_addr SHALL NOT wrap silently.
REQ-031 A stop during FETCH or LOAD SHALL go to IDLE on the next edge.
REQ-032 DONE SHALL assert song_done for 1 cycle and then go to IDLE.
REQ-033 song_done SHALL NOT pulse on a stop abort or on a loop restart.
REQ-034 start SHALL be ignored while busy=1.
REQ-035 Entering IDLE SHALL clear stop_pending and force beat_en=0 and tone_en=0.
REQ-036 Latency from start high at edge N: FETCH at N+1, LOAD at N+2, beat_en=1 at N+3.
REQ-037 Note length SHALL be beat_cnt_parameter+1 beat_en-high cycles, with the count kept by the downstream beat counter.

Reset
REQ-038 While rst=1, the state SHALL be IDLE and stop_pending, rom_addr, beat_en, beat_cnt_parameter, tone_div, tone_en, busy and song_done SHALL all be 0.
REQ-039 Reset asserted mid-note SHALL take effect immediately, without waiting for beat_finish.

Verification
(Bench settings: BEAT_UNIT=4, GAP_CYCLES=2, beat counter model attached.)
REQ-040 ROM {0:dur2,div100; 1:dur1,div0; 2:dur0} with a start pulse -> beat_cnt_parameter=7, tone_en=1 for 8 cycles; gap 2 cycles; parameter=3, tone_en=0 for 4 cycles; song_done pulses once; busy falls.
REQ-041 Same ROM with loop_en=1 -> address sequence 0,1,2,0,1,... with no song_done.
REQ-042 stop at the 3rd cycle of note 0 -> note plays all 8 cycles, then IDLE; no GAP entered; no song_done.
REQ-043 start and stop in the same cycle while in IDLE -> busy stays 0; start pulsed while busy -> rom_addr unaffected.
REQ-044 rst pulsed mid-PLAY -> all outputs 0 asynchronously; a new start plays from address 0.
REQ-045 ROM fully populated with dur1 entries (ADDR_W=2) -> 4 notes play, then song_done; rom_addr never wraps.
